frame_bram_writer: RTL and testbench

//  Write side of the frame-buffer BRAM that the LCD read path scans. Takes a byte

---
 rtl/frame_bram_writer.sv | 104 ++++++++++
 tb/tb_frame_bram_writer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/frame_bram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : frame_bram_writer                                                |
// | Purpose : Packs an 8-bit byte stream into RGB565 words and writes one full |
// |           frame to BRAM at addresses 0..IMG_W*IMG_H-1.                      |
// | Config  : FBW_BYTE_SWAP_EN - first byte of each pair is the low byte.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module frame_bram_writer #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] BRAMADDR,
   output logic [15:0]       BRAMDATA,
   output logic              BRAMWE,
   output logic              busy,
   output logic              frame_done
);

   localparam int                c_NPIX = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_NPIX - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HI   = 2'd1,
      S_LO   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_pix_addr;
   logic [7:0]        r_first_byte;
   logic              w_accept;
   logic              w_last;

   assign in_ready = (r_state == S_HI) || (r_state == S_LO);
   assign busy     = in_ready;
   // start outranks a byte offered in the same cycle
   assign w_accept = in_valid && in_ready && !start;
   assign w_last   = (r_pix_addr == c_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (start) begin
         w_next_state = S_HI;
      end else begin
         case (r_state)
            S_HI:    if (w_accept) w_next_state = S_LO;
            S_LO:    if (w_accept) w_next_state = w_last ? S_DONE : S_HI;
            default: w_next_state = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pix_addr   <= '0;
         r_first_byte <= 8'h00;
         BRAMADDR     <= '0;
         BRAMDATA     <= 16'h0000;
         BRAMWE       <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         BRAMWE <= 1'b0;
         if (start) begin
            r_pix_addr   <= '0;
            r_first_byte <= 8'h00;
            frame_done   <= 1'b0;
         end else if (w_accept && (r_state == S_HI)) begin
            r_first_byte <= in_data;
         end else if (w_accept && (r_state == S_LO)) begin
`ifdef FBW_BYTE_SWAP_EN
            BRAMDATA <= {in_data, r_first_byte};
`else
            BRAMDATA <= {r_first_byte, in_data};
`endif
            BRAMADDR   <= r_pix_addr;
            BRAMWE     <= 1'b1;
            r_pix_addr <= r_pix_addr + 1'b1;
            if (w_last) begin
               frame_done <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_bram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_frame_bram_writer                                             |
// | Purpose : Directed and randomized bench for frame_bram_writer (4x2 frame). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_frame_bram_writer;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] BRAMADDR;
   logic [15:0] BRAMDATA;
   logic        BRAMWE;
   logic        busy;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: a frame is a count of pixels written plus an optional pending byte
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_have = 1'b0;
   logic [7:0]  m_first = 8'h00;
   int          m_count = 0;
   logic        exp_we = 1'b0;
   logic [15:0] exp_addr = 16'h0000;
   logic [15:0] exp_data = 16'h0000;

   frame_bram_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .BRAMADDR(BRAMADDR), .BRAMDATA(BRAMDATA), .BRAMWE(BRAMWE),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pair(input logic [7:0] first, input logic [7:0] second);
`ifdef FBW_BYTE_SWAP_EN
      return {second, first};
`else
      return {first, second};
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_done = 1'b0; m_have = 1'b0; m_first = 8'h00; m_count = 0;
      exp_we = 1'b0; exp_addr = 16'h0000; exp_data = 16'h0000;
   endtask

   // one clock: drive at posedge+1, check decode, advance model, check registered outputs
   task automatic cycle(input bit s, input bit v, input logic [7:0] d);
      start = s; in_valid = v; in_data = d;
      #1;
      chk("in_ready", in_ready, m_busy);
      chk("busy", busy, m_busy);
      exp_we = 1'b0;
      if (s) begin
         m_busy = 1'b1; m_done = 1'b0; m_have = 1'b0; m_count = 0;
      end else if (m_busy && v) begin
         if (!m_have) begin
            m_first = d; m_have = 1'b1;
         end else begin
            exp_we = 1'b1; exp_addr = 16'(m_count); exp_data = pair(m_first, d);
            m_have = 1'b0; m_count++;
            if (m_count == NPIX) begin
               m_busy = 1'b0; m_done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("bramwe", BRAMWE, exp_we);
      chk("bramaddr", BRAMADDR, exp_addr);
      chk("bramdata", BRAMDATA, exp_data);
      chk("frame_done", frame_done, m_done);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_we"}, BRAMWE, 0);
      chk({tag, "_addr"}, BRAMADDR, 0);
      chk({tag, "_data"}, BRAMDATA, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, in_ready, 0);
      chk({tag, "_done"}, frame_done, 0);
   endtask

   initial begin
      int k;
      // reset then idle, bytes offered without start are ignored
      #2;
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i));

      // full-rate frame 0x00..0x0F
      cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'(i));
      chk("t2_done", frame_done, 1);
      chk("t2_last_addr", BRAMADDR, 7);
      chk("t2_last_data", BRAMDATA, pair(8'h0E, 8'h0F));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hEE);
      chk("t2_busy_after", busy, 0);

      // same frame with in_valid toggling every cycle
      cycle(1'b1, 1'b0, 8'h00);
      k = 0;
      for (int i = 0; i < 32; i++) begin
         if (i % 2 == 0) begin
            cycle(1'b0, 1'b1, 8'(k));
            k++;
         end else begin
            cycle(1'b0, 1'b0, 8'($urandom));
         end
      end
      chk("t3_done", frame_done, 1);

      // restart after 5 bytes; the half pixel and the byte alongside start are dropped
      cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h10 + i));
      cycle(1'b1, 1'b1, 8'h55);
      cycle(1'b0, 1'b1, 8'hAA);
      cycle(1'b0, 1'b1, 8'hBB);
      chk("t4_we", BRAMWE, 1);
      chk("t4_addr", BRAMADDR, 0);
      chk("t4_data", BRAMDATA, pair(8'hAA, 8'hBB));

      // byte order of a pair
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h34);
      cycle(1'b0, 1'b1, 8'h12);
`ifdef FBW_BYTE_SWAP_EN
      chk("t5_data", BRAMDATA, 16'h1234);
`else
      chk("t5_data", BRAMDATA, 16'h3412);
`endif
      chk("t5_addr", BRAMADDR, 0);

      // reset mid-frame after addr 3 is written
      cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom));
      chk("t6_addr_before", BRAMADDR, 3);
      start = 1'b0; in_valid = 1'b1;
      rst = 1'b1;
      #1;
      check_zero("t6_rst");
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h5A);
      cycle(1'b0, 1'b1, 8'hA5);
      chk("t6_restart_addr", BRAMADDR, 0);
      chk("t6_restart_data", BRAMDATA, pair(8'h5A, 8'hA5));

      // randomized frames with sparse valid and occasional restarts
      for (int f = 0; f < 6; f++) begin
         cycle(1'b1, 1'b0, 8'h00);
         for (int i = 0; i < 50; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
